// File: rtl/multiplier_24bit_seq.sv
// multiplier_24bit_seq
//   Iterative radix-2 shift-and-add unsigned multiplier for the FPU mantissa
//   datapath. One conditional add and one right shift per clock through a
//   single N+1 bit adder. The result is presented N+1 cycles after the start
//   edge, independent of the operand values.
//
//   Optional build macro: MULT_NORM_EN
//     When defined, a normalizer is built on the completing product and
//     registered alongside it. When undefined, mant_out, norm_shift, guard
//     and sticky are tied to 0.
//
// Ports
//   clk         in   1    clock, rising edge
//   rst         in   1    synchronous active-high reset
//   start       in   1    request, sampled only in IDLE
//   num1        in   N    multiplicand, captured on accept
//   num2        in   N    multiplier, captured on accept
//   busy        out  1    high in BUSY and DONE
//   done        out  1    one-cycle pulse, product valid
//   product     out  2N   num1*num2, held until the next completion
//   mant_out    out  N    normalized mantissa (MULT_NORM_EN)
//   norm_shift  out  1    product MSB set, exponent +1 (MULT_NORM_EN)
//   guard       out  1    first bit below mant_out LSB (MULT_NORM_EN)
//   sticky      out  1    OR of all bits below guard (MULT_NORM_EN)
//
// state | meaning
// IDLE  | waiting for start, operands captured on accept
// BUSY  | N add/shift iterations, then one cycle to register the product
// DONE  | product valid, done pulse, return to IDLE on next edge

module multiplier_24bit_seq #(
  parameter int N     = 24,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   num1,
  input  logic [N-1:0]   num2,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [N-1:0]   mant_out,
  output logic           norm_shift,
  output logic           guard,
  output logic           sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     mcand;
  logic [N-1:0]     mplier;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       sum;
  logic [2*N-1:0]   full;
  logic             iter_end;
  logic             capture;

  // Carry out of the add is kept and shifted back into acc.
  assign sum      = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign full     = {acc, mplier};
  // cnt reaches N once all iterations are done; that cycle registers the result.
  assign iter_end = (cnt == CNT_W'(N));
  assign capture  = (state == BUSY) && iter_end;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (iter_end) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= num1;
            mplier <= num2;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (iter_end) begin
            product <= full;
          end else begin
            {acc, mplier} <= {sum, mplier[N-1:1]};
            cnt           <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_NORM_EN
  logic [N-1:0] mant_nxt;
  logic         shift_nxt;
  logic         guard_nxt;
  logic         sticky_nxt;

  always_comb begin
    mant_nxt   = '0;
    shift_nxt  = 1'b0;
    guard_nxt  = 1'b0;
    sticky_nxt = 1'b0;
    if (full[2*N-1]) begin
      shift_nxt  = 1'b1;
      mant_nxt   = full[2*N-1:N];
      guard_nxt  = full[N-1];
      sticky_nxt = |full[N-2:0];
    end else begin
      mant_nxt   = full[2*N-2:N-1];
      guard_nxt  = full[N-2];
      sticky_nxt = |full[N-3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mant_out   <= '0;
      norm_shift <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
    end else if (capture) begin
      mant_out   <= mant_nxt;
      norm_shift <= shift_nxt;
      guard      <= guard_nxt;
      sticky     <= sticky_nxt;
    end
  end
`else
  assign mant_out   = '0;
  assign norm_shift = 1'b0;
  assign guard      = 1'b0;
  assign sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_24bit_seq.sv
module tb_multiplier_24bit_seq;

  localparam int N = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  num1, num2;
  logic          busy, done;
  logic [47:0]   product;
  logic [N-1:0]  mant_out;
  logic          norm_shift, guard, sticky;

  int pass_cnt = 0;
  int total    = 0;

  multiplier_24bit_seq #(.N(24), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
    .busy(busy), .done(done), .product(product), .mant_out(mant_out),
    .norm_shift(norm_shift), .guard(guard), .sticky(sticky)
  );

  always #5 clk = ~clk;

  // Reference: plain integer multiply, then the normalization rule on the result.
  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    longint unsigned x, y;
    x = longint'(a);
    y = longint'(b);
    return 48'(x * y);
  endfunction

  function automatic logic [26:0] ref_norm(input logic [47:0] p);
    // {norm_shift, mant_out, guard, sticky}
`ifdef MULT_NORM_EN
    if (p[47]) return {1'b1, p[47:24], p[23], |p[22:0]};
    else       return {1'b0, p[46:23], p[22], |p[21:0]};
`else
    return {p[0] & 1'b0, 26'd0};
`endif
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp_v);
    total++;
    if (act !== exp_v) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    else pass_cnt++;
  endtask

  // Runs one operation from IDLE; checks latency, product, norm, one done pulse.
  task automatic run_op(input string name, input logic [23:0] a, input logic [23:0] b);
    logic [47:0] prev, exp_p;
    logic [26:0] exp_n;
    int edges, held_bad;
    bit got;
    prev     = product;
    exp_p    = ref_mul(a, b);
    exp_n    = ref_norm(exp_p);
    num1 = a; num2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num1 = $urandom; num2 = $urandom;
    edges = 0; got = 0; held_bad = 0;
    while (edges < 40 && !got) begin
      @(posedge clk); #1;
      edges++;
      if (done) got = 1;
      else if (product !== prev || !busy) held_bad++;
    end
    chk({name, " latency"}, 48'(edges), 48'd25);
    chk({name, " held"}, 48'(held_bad), 48'd0);
    chk({name, " product"}, product, exp_p);
    chk({name, " busy_done"}, {47'd0, busy}, 48'd1);
    chk({name, " norm"}, {21'd0, norm_shift, mant_out, guard, sticky}, {21'd0, exp_n});
    @(posedge clk); #1;
    chk({name, " end"}, {46'd0, busy, done}, 48'd0);
    chk({name, " stable"}, product, exp_p);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num1 = '0; num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy_done", {46'd0, busy, done}, 48'd0);
    chk("reset product", product, 48'd0);
    chk("reset norm", {21'd0, norm_shift, mant_out, guard, sticky}, 48'd0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op("c0xc0", 24'hC00000, 24'hC00000);
    chk("c0xc0 value", product, 48'h900000000000);
    run_op("80x80", 24'h800000, 24'h800000);
    chk("80x80 value", product, 48'h400000000000);
    run_op("ffxff", 24'hFFFFFF, 24'hFFFFFF);
    chk("ffxff value", product, 48'hFFFFFE000001);
`ifdef MULT_NORM_EN
    chk("ffxff norm", {21'd0, norm_shift, mant_out, guard, sticky}, {21'd0, 1'b1, 24'hFFFFFE, 1'b0, 1'b1});
`endif
    run_op("zero", 24'h000000, 24'hABCDEF);
    chk("zero value", product, 48'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [23:0] a, b;
      a = 24'($urandom);
      b = 24'($urandom);
      if (i == 0) a[23] = 1'b1;
      run_op($sformatf("rand%0d", i), a, b);
    end
  endtask

  task automatic test_start_ignored();
    logic [47:0] exp_p;
    int ndone, edges;
    exp_p = ref_mul(24'h123456, 24'h0789AB);
    num1 = 24'h123456; num2 = 24'h0789AB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; edges = 0;
    while (edges < 45) begin
      if (edges == 5) begin num1 = 24'hFFFFFF; num2 = 24'hFFFFFF; start = 1'b1; end
      else if (edges == 6) start = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (done) begin
        ndone++;
        chk("ignored product", product, exp_p);
        chk("ignored latency", 48'(edges), 48'd25);
      end
    end
    chk("ignored ndone", 48'(ndone), 48'd1);
    chk("ignored idle", {47'd0, busy}, 48'd0);
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp_p;
    int ndone;
    exp_p = ref_mul(24'h00ABCD, 24'h001234);
    num1 = 24'h00ABCD; num2 = 24'h001234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    chk("b2b done", {47'd0, done}, 48'd1);
    // start asserted during DONE must not be accepted
    num1 = 24'h000007; num2 = 24'h000009; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b idle", {46'd0, busy, done}, 48'd0);
    ndone = 0;
    repeat (30) begin @(posedge clk); #1; if (done || busy) ndone++; end
    chk("b2b no_op", 48'(ndone), 48'd0);
    chk("b2b product", product, exp_p);
    run_op("b2b next", 24'h000007, 24'h000009);
  endtask

  task automatic test_reset_mid();
    int busy_seen;
    num1 = 24'hABCDEF; num2 = 24'h123456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1; start = 1'b1; num1 = 24'h111111; num2 = 24'h222222;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrst busy_done", {46'd0, busy, done}, 48'd0);
    chk("midrst product", product, 48'd0);
    chk("midrst norm", {21'd0, norm_shift, mant_out, guard, sticky}, 48'd0);
    busy_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (busy || done) busy_seen++; end
    chk("midrst start_discarded", 48'(busy_seen), 48'd0);
    run_op("after_rst", 24'h000003, 24'h000005);
    chk("after_rst value", product, 48'hF);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total);
    $fatal(1, "timeout");
  end

endmodule
